// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small program and feeds it word by word to the
// processor over din/run, following mvi with its immediate and waiting for done.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          done,
  output logic [15:0]   din,
  output logic          run,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [7:0]    icount,
  output logic [2:0]    dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t        r_state;
  logic [15:0]   r_din;
  logic          r_run;
  logic [AW:0]   r_pc;
  logic [AW:0]   r_len;
  logic [TW-1:0] r_tcnt;
  logic [1:0]    r_err_code;
  logic [7:0]    r_icount;
  logic [15:0]   r_mem [DEPTH];

  state_t        w_next_state;
  logic [15:0]   w_din;
  logic [AW:0]   w_pc;
  logic [AW:0]   w_len;
  logic [TW-1:0] w_tcnt;
  logic [1:0]    w_err_code;
  logic [7:0]    w_icount;
  logic [AW:0]   w_pc_inc1;
  logic          w_is_mvi;
  logic          w_busy;

  assign w_busy    = (r_state == S_ISSUE) || (r_state == S_IMM) || (r_state == S_WAIT);
  assign w_pc_inc1 = r_pc + 1'b1;
  // During ISSUE din still holds the word being issued, so its opcode decides the path.
  assign w_is_mvi  = (r_din[15:13] == 3'b001);

  always_comb begin
    w_next_state = r_state;
    w_din        = r_din;
    w_pc         = r_pc;
    w_len        = r_len;
    w_tcnt       = r_tcnt;
    w_err_code   = r_err_code;
    w_icount     = r_icount;
    case (r_state)
      S_IDLE, S_HALT, S_ERROR: begin
        if (start) begin
          w_len      = prog_len;
          w_pc       = '0;
          w_icount   = '0;
          w_err_code = 2'b00;
          if (prog_len == '0) begin
            w_next_state = S_HALT;
          end else begin
            w_next_state = S_ISSUE;
            w_din        = r_mem[0];
          end
        end
      end
      S_ISSUE: begin
        w_tcnt = '0;
        if (w_is_mvi) begin
          if (w_pc_inc1 < r_len) begin
            w_next_state = S_IMM;
            w_din        = r_mem[w_pc_inc1[AW-1:0]];
            w_pc         = r_pc + 2'd2;
          end else begin
            w_next_state = S_ERROR;
            w_err_code   = 2'b10;
          end
        end else begin
          w_next_state = S_WAIT;
          w_pc         = w_pc_inc1;
        end
      end
      S_IMM, S_WAIT: begin
        // done takes priority over a timeout landing in the same cycle.
        if (done) begin
          if (r_icount != 8'hFF) w_icount = r_icount + 1'b1;
          if (r_pc == r_len) begin
            w_next_state = S_HALT;
          end else begin
            w_next_state = S_ISSUE;
            w_din        = r_mem[r_pc[AW-1:0]];
          end
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_next_state = S_ERROR;
          w_err_code   = 2'b01;
        end else begin
          w_next_state = S_WAIT;
          w_tcnt       = r_tcnt + 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_din      <= '0;
      r_run      <= 1'b0;
      r_pc       <= '0;
      r_len      <= '0;
      r_tcnt     <= '0;
      r_err_code <= 2'b00;
      r_icount   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_din      <= w_din;
      r_run      <= (w_next_state == S_ISSUE);
      r_pc       <= w_pc;
      r_len      <= w_len;
      r_tcnt     <= w_tcnt;
      r_err_code <= w_err_code;
      r_icount   <= w_icount;
    end
  end

  // Program storage survives reset so a bench can reload once and rerun.
  always_ff @(posedge clock) begin
    if (load_en && !w_busy) r_mem[load_addr] <= load_data;
  end

  assign din       = r_din;
  assign run       = r_run;
  assign pc        = r_pc;
  assign busy      = w_busy;
  assign halted    = (r_state == S_HALT);
  assign err       = (r_state == S_ERROR);
  assign err_code  = r_err_code;
  assign icount    = r_icount;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: issued din words are checked against a queue of
// expected words; each scenario task checks its own status outputs inline.
module tb_instr_sequencer;

  localparam int AW      = 4;
  localparam int TIMEOUT = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [15:0]   load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          done = 1'b0;
  logic [15:0]   din;
  logic          run;
  logic [AW:0]   pc;
  logic          busy;
  logic          halted;
  logic          err;
  logic [1:0]    err_code;
  logic [7:0]    icount;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  instr_sequencer #(.DEPTH(16), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .done(done),
    .din(din), .run(run), .pc(pc), .busy(busy), .halted(halted), .err(err),
    .err_code(err_code), .icount(icount), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    @(negedge clock);
    prog_len = len; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits (bounded) for a run pulse at a negedge and pops the scoreboard on it.
  task automatic wait_run(output bit found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      if (run === 1'b1) found = 1'b1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run_timeout: no run pulse within 200 cycles");
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected_run: din=%h issued, no word expected", din);
    end else begin
      logic [15:0] e;
      e = exp_q.pop_front();
      if (din !== e) begin
        errors++;
        $display("FAIL sb_din: got %h expected %h", din, e);
      end
    end
  endtask

  task automatic done_after(input int d);
    repeat (d) @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
  endtask

  task automatic run_program(input logic [AW:0] len, input int d, input int n, output int seen);
    bit f;
    seen = 0;
    pulse_start(len);
    for (int i = 0; i < n; i++) begin
      wait_run(f);
      if (!f) break;
      seen++;
      done_after(d);
    end
  endtask

  task automatic test_reset;
    bit f;
    int seen;
    repeat (3) @(negedge clock);
    checks++;
    if ({din, run, pc, busy, halted, err, err_code, icount, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values: din=%h run=%b pc=%0d busy=%b halted=%b err=%b code=%b icount=%0d state=%0d, all zero required",
               din, run, pc, busy, halted, err, err_code, icount, dbg_state);
    end
    reset = 1'b0;
    load_word(0, 16'h4000);
    load_word(1, 16'h6000);
    load_word(2, 16'h8000);
    exp_q.push_back(16'h4000);
    pulse_start(3);
    wait_run(f);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (run !== 1'b0 || din !== 16'h0 || busy !== 1'b0 || pc !== '0) begin
      errors++;
      $display("FAIL reset_midrun: run=%b din=%h busy=%b pc=%0d, required 0/0000/0/0", run, din, busy, pc);
    end
    reset = 1'b0;
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h6000);
    exp_q.push_back(16'h8000);
    run_program(3, 3, 3, seen);
    checks++;
    if (seen != 3 || halted !== 1'b1 || icount !== 8'd3) begin
      errors++;
      $display("FAIL reset_rerun: runs=%0d halted=%b icount=%0d, required 3/1/3", seen, halted, icount);
    end
  endtask

  task automatic test_single_word;
    int seen;
    load_word(0, 16'h4000);
    load_word(1, 16'h6000);
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h6000);
    run_program(2, 3, 2, seen);
    checks++;
    if (seen != 2 || icount !== 8'd2 || halted !== 1'b1 || pc !== 5'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_word: runs=%0d icount=%0d halted=%b pc=%0d busy=%b, required 2/2/1/2/0",
               seen, icount, halted, pc, busy);
    end
  endtask

  task automatic test_mvi;
    bit f;
    load_word(0, 16'h2000);
    load_word(1, 16'h0005);
    exp_q.push_back(16'h2000);
    pulse_start(2);
    wait_run(f);
    @(negedge clock);
    checks++;
    if (run !== 1'b0 || din !== 16'h0005 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mvi_imm: run=%b din=%h busy=%b, required 0/0005/1", run, din, busy);
    end
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    checks++;
    if (halted !== 1'b1 || icount !== 8'd1 || err !== 1'b0 || pc !== 5'd2) begin
      errors++;
      $display("FAIL mvi_done: halted=%b icount=%0d err=%b pc=%0d, required 1/1/0/2", halted, icount, err, pc);
    end
  endtask

  task automatic test_truncated_mvi;
    bit f;
    load_word(0, 16'h2000);
    exp_q.push_back(16'h2000);
    pulse_start(1);
    wait_run(f);
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || halted !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL trunc_mvi: err=%b code=%b halted=%b busy=%b, required 1/10/0/0", err, err_code, halted, busy);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (run !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL trunc_sticky: run=%b err=%b, required 0/1", run, err);
    end
  endtask

  task automatic test_timeout;
    bit f;
    load_word(0, 16'h4000);
    exp_q.push_back(16'h4000);
    pulse_start(1);
    wait_run(f);
    repeat (TIMEOUT) @(negedge clock);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: err=%b busy=%b at cycle %0d, required 0/1", err, busy, TIMEOUT);
    end
    @(negedge clock);
    checks++;
    if (err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%b code=%b busy=%b, required 1/01/0", err, err_code, busy);
    end
    exp_q.push_back(16'h4000);
    pulse_start(1);
    wait_run(f);
    done_after(TIMEOUT);
    checks++;
    if (halted !== 1'b1 || err !== 1'b0 || err_code !== 2'b00 || icount !== 8'd1) begin
      errors++;
      $display("FAIL timeout_done_wins: halted=%b err=%b code=%b icount=%0d, required 1/0/00/1",
               halted, err, err_code, icount);
    end
  endtask

  task automatic test_edges;
    bit f;
    int seen;
    pulse_start(0);
    checks++;
    if (halted !== 1'b1 || run !== 1'b0 || busy !== 1'b0 || pc !== '0 || icount !== 8'd0) begin
      errors++;
      $display("FAIL len_zero: halted=%b run=%b busy=%b pc=%0d icount=%0d, required 1/0/0/0/0",
               halted, run, busy, pc, icount);
    end
    load_word(0, 16'h4000);
    load_word(1, 16'h6000);
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h6000);
    pulse_start(2);
    wait_run(f);
    @(negedge clock);
    start = 1'b1; prog_len = 5'd1;
    load_en = 1'b1; load_addr = 0; load_data = 16'hFFFF;
    @(negedge clock);
    start = 1'b0; load_en = 1'b0;
    checks++;
    if (pc !== 5'd1 || run !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: pc=%0d run=%b busy=%b, required 1/0/1", pc, run, busy);
    end
    done_after(0);
    wait_run(f);
    done_after(2);
    checks++;
    if (halted !== 1'b1 || icount !== 8'd2) begin
      errors++;
      $display("FAIL busy_prog_end: halted=%b icount=%0d, required 1/2", halted, icount);
    end
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h6000);
    run_program(2, 1, 2, seen);
    checks++;
    if (seen != 2 || halted !== 1'b1 || icount !== 8'd2 || pc !== 5'd2) begin
      errors++;
      $display("FAIL rerun_from_halt: runs=%0d halted=%b icount=%0d pc=%0d, required 2/1/2/2",
               seen, halted, icount, pc);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_mvi();
    test_truncated_mvi();
    test_timeout();
    test_edges();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || run !== 1'b0) begin
      errors++;
      $display("FAIL sb_drain: %0d words still expected, run=%b", exp_q.size(), run);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
